// File: rtl/irq_controller.sv
// irq_controller: edge-captured interrupt sources with a mask register, a
// request/service handshake with the pipeline, and kernel-mode blocking.
// Build option: define IRQ_ROUND_ROBIN_EN for rotating-priority arbitration.
// Without it, arbitration is fixed and the lowest index wins.
module irq_controller #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            PC31,
    input  logic            irq_ack,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic [1:0]      irq_id,
    output logic            in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_src_hist;
    logic            r_armed;
    logic            r_pc31_prev;
    logic [1:0]      r_irq_id;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_pending_next;
    logic [NSRC-1:0] w_req_vec;
    logic            w_irq;
    logic            w_ack_take;
    logic            w_have_req;
    logic [1:0]      w_winner;
    logic            w_unused_wdata;

    // Only the low NSRC bits of the write data are meaningful.
    assign w_unused_wdata = ^wdata[31:NSRC];

    // The request is visible only outside kernel mode and only while its
    // source remains unmasked, so a mask clear withdraws it at once.
    assign w_irq      = (r_state == ST_REQ) && !PC31 && r_mask[r_irq_id];
    assign w_ack_take = w_irq && irq_ack;
    assign w_req_vec  = r_pending & r_mask;
    assign w_have_req = |w_req_vec;

    // r_armed keeps the first cycle after reset from reading a level-high
    // source as an edge while the history register catches up.
    assign w_edge = src & ~r_src_hist & {NSRC{r_armed}};
    assign w_w1c  = (we && (addr == 2'd1)) ? wdata[NSRC-1:0] : '0;

    // Per-bit pending update: a new edge always beats either kind of clear.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign w_ack_clr[gi]      = w_ack_take && (r_irq_id == 2'(gi));
            assign w_pending_next[gi] = w_edge[gi] |
                                        (r_pending[gi] & ~w_w1c[gi] & ~w_ack_clr[gi]);
        end
    endgenerate

`ifdef IRQ_ROUND_ROBIN_EN
    logic [1:0] r_last_id;

    // Rotating priority: search upward from the source after the last acked one.
    always_comb begin
        int idx;
        idx      = 0;
        w_winner = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = (int'(r_last_id) + 1 + k) % NSRC;
            if (w_req_vec[idx]) begin
                w_winner = 2'(idx);
            end
        end
    end

    // Remember which source was most recently acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_id <= 2'(NSRC - 1);
        end else if (w_ack_take) begin
            r_last_id <= r_irq_id;
        end
    end
`else
    // Fixed priority: the lowest pending, unmasked index wins.
    always_comb begin
        w_winner = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (w_req_vec[k]) begin
                w_winner = 2'(k);
            end
        end
    end
`endif

    // Source history, PC31 history, mask and pending registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_hist  <= '0;
            r_armed     <= 1'b0;
            r_pc31_prev <= 1'b0;
            r_mask      <= '0;
            r_pending   <= '0;
        end else begin
            r_src_hist  <= src;
            r_armed     <= 1'b1;
            r_pc31_prev <= PC31;
            r_pending   <= w_pending_next;
            if (we && (addr == 2'd0)) begin
                r_mask <= wdata[NSRC-1:0];
            end
        end
    end

    // Request/service sequencing with the granted id latched on entry to REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_irq_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_have_req && !PC31) begin
                        r_irq_id <= w_winner;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!r_mask[r_irq_id]) begin
                        r_state <= ST_IDLE;
                    end else if (w_ack_take) begin
                        r_state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (r_pc31_prev && !PC31) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign irq        = w_irq;
    assign irq_id     = r_irq_id;
    assign in_service = (r_state == ST_SERVICE);

    // Register read mux, purely combinational from addr.
    always_comb begin
        case (addr)
            2'd0:    rdata = {{(32-NSRC){1'b0}}, r_mask};
            2'd1:    rdata = {{(32-NSRC){1'b0}}, r_pending};
            2'd2:    rdata = {27'b0, in_service, irq, 1'b0, irq_id};
            default: rdata = 32'd0;
        endcase
    end

endmodule
